intersection_ctrl: RTL
======================

Name: intersection_ctrl

Overview:
- Four-way intersection sequencer. Drives two 12-bit RGB light heads (north-south, east-west) and one pedestrian WALK lamp.
- Auto mode: phases are timed in whole seconds from a 1 s tick. Manual mode: the pulse input advances one phase per pulse.
- Latches pedestrian requests and inserts a WALK phase after the next all-red clearance.
- Sits above the single-head light block and replaces its one-lamp state machine at board top level.

Parameters:
- TICKS_PER_SEC, 1_000_000: clk cycles per second tick (1 MHz board clock).
- GREEN_S, 5: green duration in seconds (1..15).
- YELLOW_S, 2: yellow duration in seconds (1..15).
- ALLRED_S, 1: all-red clearance in seconds (1..15).
- PED_S, 4: WALK duration in seconds (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- mode  in  1  0 = auto (timed), 1 = manual (pulse-stepped)
- pulse  in  1  single-cycle step request, used only when mode=1
- ped_req  in  1  pedestrian button, level or pulse
- ns_rgb  out  12  {r,g,b} for north-south head, 4 bits each
- ew_rgb  out  12  {r,g,b} for east-west head, 4 bits each
- ped_walk  out  1  WALK lamp
- state_o  out  3  current state code, for debug/LED display

Interface: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- States: RST_S=0, NS_G=1, NS_Y=2, ALL_R=3, EW_G=4, EW_Y=5, PED=6.
- Registers: state, tick_cnt (20 b), sec_cnt (4 b), next_dir (0=NS, 1=EW), ped_pend.
- Reset (async): state=RST_S, tick_cnt=0, sec_cnt=0, next_dir=NS, ped_pend=0.
- Outputs in RST_S: ns_rgb=ew_rgb=0, ped_walk=0, state_o=0.
- Outputs are combinational from state (zero latency). Colour codes: RED=F00, GREEN=0F0, YELLOW=FF0, OFF=000.
- Per-state outputs:
  - NS_G: ns=GREEN, ew=RED.
  - NS_Y: ns=YELLOW, ew=RED.
  - EW_G: ew=GREEN, ns=RED.
  - EW_Y: ew=YELLOW, ns=RED.
  - ALL_R and PED: both RED.
  - ped_walk=1 only in PED.
- Tick generation:
  - sec_tick=1 when mode=0 and tick_cnt==TICKS_PER_SEC-1; tick_cnt then wraps to 0.
  - mode=1 holds tick_cnt at 0.
- Phase advance:
  - adv = (mode=0 & sec_tick & sec_cnt==DUR(state)-1) | (mode=1 & pulse).
  - On adv: sec_cnt<=0. Otherwise sec_cnt increments on each sec_tick.
  - mode=1 clears sec_cnt every cycle.
- Transitions:
  - RST_S -> ALL_R unconditionally after one cycle.
  - NS_G -> NS_Y -> ALL_R on adv; NS_Y exit sets next_dir=EW.
  - EW_G -> EW_Y -> ALL_R on adv; EW_Y exit sets next_dir=NS.
  - ALL_R on adv: if ped_pend -> PED; else next_dir ? EW_G : NS_G.
  - PED on adv -> next_dir ? EW_G : NS_G.
  - Illegal state codes -> RST_S.
- ped_pend:
  - Set by ped_req=1 in any state except PED.
  - Cleared on the cycle of entry into PED. A ped_req on that same cycle is absorbed.
  - ped_req during PED is ignored.
- Mode switch mid-phase: the state is held. Auto timing of the current phase restarts from sec_cnt=0.
- pulse while mode=0 is ignored. pulse held high advances once per cycle; debouncing and edge detection are done upstream.
- rst asserted mid-phase returns to RST_S immediately; ped_pend is lost.

Optional Feature:
- Macro: INTERSECTION_NIGHT_FLASH_EN.
- When defined:
  - Adds input night (1 b) and state FLASH=7.
  - While night=1 and mode=0, any state goes to FLASH on the next clk.
  - In FLASH, both heads toggle YELLOW/OFF on every sec_tick, starting at YELLOW. ped_walk=0 and ped_req is ignored (ped_pend held at 0).
  - When night falls to 0: FLASH -> ALL_R with next_dir=NS and sec_cnt=0.
- When not defined: the night port and FLASH state are absent, and state code 7 is illegal (-> RST_S).

Decomposition:
- Package traffic_pkg:
  - 3-bit state encodings RST_S..FLASH.
  - 12-bit colour constants RED/GREEN/YELLOW/OFF.
  - Function dur_of(state) returning the parameter duration.
- Sub-module sec_tick_gen (params TICKS_PER_SEC; ports clk, rst, en, tick):
  - Free-running tick_cnt.
  - en=0 clears the counter.
  - Reused by other timed blocks.

Test Plan:
- Run with TICKS_PER_SEC=4, GREEN_S=3, YELLOW_S=2, ALLRED_S=1, PED_S=2.
- Reset release, mode=0 -> state_o 0 for 1 cycle, then 3 for 4 cycles, then NS_G (ns_rgb=0F0, ew_rgb=F00) for 12 cycles, then NS_Y for 8 cycles, then ALL_R for 4, then EW_G.
- ped_req 1-cycle pulse during NS_G -> after NS_Y and ALL_R, PED for 8 cycles with ped_walk=1 and both heads F00, then EW_G; ped_pend=0.
- mode=1, pulses 5 cycles apart -> one state step per pulse; no change between pulses; sec_cnt and tick_cnt stay 0.
- Switch mode 1->0 in the middle of EW_G -> EW_G lasts a full 12 cycles from the switch.
- Assert rst for 1 cycle during PED -> outputs 000/000 and ped_walk=0 immediately; the sequence restarts at ALL_R then NS_G.
- With INTERSECTION_NIGHT_FLASH_EN: night=1 -> FLASH, both heads alternate FF0/000 every 4 cycles; night=0 -> ALL_R then NS_G.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state encodings, colour codes and phase-duration lookup for the traffic blocks.
// Define INTERSECTION_NIGHT_FLASH_EN to include the FLASH state.
package traffic_pkg;

  typedef enum logic [2:0] {
    RST_S = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    ALL_R = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    PED   = 3'd6
`ifdef INTERSECTION_NIGHT_FLASH_EN
    , FLASH = 3'd7
`endif
  } state_t;

  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] GREEN  = 12'h0F0;
  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic [11:0] OFF    = 12'h000;

  // States without a timed phase report one second so the compare stays well-formed.
  function automatic logic [3:0] dur_of(input state_t s, input int green_s, input int yellow_s,
                                        input int allred_s, input int ped_s);
    logic [3:0] d;
    d = 4'd1;
    case (s)
      NS_G, EW_G: d = 4'(green_s);
      NS_Y, EW_Y: d = 4'(yellow_s);
      ALL_R:      d = 4'(allred_s);
      PED:        d = 4'(ped_s);
      default:    d = 4'd1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-cycle tick every TICKS_PER_SEC clocks; deasserting en clears the count so the
// next second starts fresh.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 1_000_000,
  parameter int CNT_W         = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] tick_cnt;

  assign tick = en && (tick_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (!en || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_ctrl.sv
// Four-way intersection sequencer with pedestrian insertion and manual stepping.
// Define INTERSECTION_NIGHT_FLASH_EN to add the night input and the flashing-yellow state.
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1_000_000,
  parameter int GREEN_S       = 5,
  parameter int YELLOW_S      = 2,
  parameter int ALLRED_S      = 1,
  parameter int PED_S         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        pulse,
  input  logic        ped_req,
`ifdef INTERSECTION_NIGHT_FLASH_EN
  input  logic        night,
`endif
  output logic [11:0] ns_rgb,
  output logic [11:0] ew_rgb,
  output logic        ped_walk,
  output logic [2:0]  state_o
);

  state_t     state;
  logic [3:0] sec_cnt;
  logic       next_dir;
  logic       ped_pend;
  logic       tick_en;
  logic       sec_tick;
  logic       adv;
`ifdef INTERSECTION_NIGHT_FLASH_EN
  logic       flash_on;

  // Counter is held clear on entry to and exit from FLASH so both start on a whole second.
  assign tick_en = !mode && (state != RST_S) && (night == (state == FLASH));
`else
  assign tick_en = !mode && (state != RST_S);
`endif

  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .CNT_W        (20)
  ) u_sec_tick (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .tick(sec_tick)
  );

  assign adv = (!mode && sec_tick &&
                (sec_cnt == dur_of(state, GREEN_S, YELLOW_S, ALLRED_S, PED_S) - 4'd1))
             || (mode && pulse);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_S;
      sec_cnt  <= 4'd0;
      next_dir <= 1'b0;
      ped_pend <= 1'b0;
`ifdef INTERSECTION_NIGHT_FLASH_EN
      flash_on <= 1'b0;
`endif
    end else begin
      if (mode || adv) begin
        sec_cnt <= 4'd0;
      end else if (sec_tick) begin
        sec_cnt <= sec_cnt + 4'd1;
      end

      if (ped_req && state != PED) begin
        ped_pend <= 1'b1;
      end

`ifdef INTERSECTION_NIGHT_FLASH_EN
      if (night && !mode) begin
        state    <= FLASH;
        ped_pend <= 1'b0;
        sec_cnt  <= 4'd0;
        if (state != FLASH) begin
          flash_on <= 1'b1;
        end else if (sec_tick) begin
          flash_on <= !flash_on;
        end
      end else
`endif
      // Later assignments to ped_pend override the request latch above, so PED entry wins.
      case (state)
        RST_S: state <= ALL_R;
        NS_G:  if (adv) state <= NS_Y;
        NS_Y:  if (adv) begin
                 state    <= ALL_R;
                 next_dir <= 1'b1;
               end
        EW_G:  if (adv) state <= EW_Y;
        EW_Y:  if (adv) begin
                 state    <= ALL_R;
                 next_dir <= 1'b0;
               end
        ALL_R: if (adv) begin
                 if (ped_pend) begin
                   state    <= PED;
                   ped_pend <= 1'b0;
                 end else begin
                   state <= next_dir ? EW_G : NS_G;
                 end
               end
        PED:   if (adv) state <= next_dir ? EW_G : NS_G;
`ifdef INTERSECTION_NIGHT_FLASH_EN
        FLASH: begin
                 ped_pend <= 1'b0;
                 sec_cnt  <= 4'd0;
                 if (!night) begin
                   state    <= ALL_R;
                   next_dir <= 1'b0;
                 end
               end
`endif
        default: state <= RST_S;
      endcase
    end
  end

  always_comb begin
    ns_rgb   = OFF;
    ew_rgb   = OFF;
    ped_walk = 1'b0;
    case (state)
      NS_G:  begin ns_rgb = GREEN;  ew_rgb = RED;    end
      NS_Y:  begin ns_rgb = YELLOW; ew_rgb = RED;    end
      EW_G:  begin ns_rgb = RED;    ew_rgb = GREEN;  end
      EW_Y:  begin ns_rgb = RED;    ew_rgb = YELLOW; end
      ALL_R: begin ns_rgb = RED;    ew_rgb = RED;    end
      PED:   begin ns_rgb = RED;    ew_rgb = RED;    ped_walk = 1'b1; end
`ifdef INTERSECTION_NIGHT_FLASH_EN
      FLASH: begin
               ns_rgb = flash_on ? YELLOW : OFF;
               ew_rgb = flash_on ? YELLOW : OFF;
             end
`endif
      default: begin ns_rgb = OFF; ew_rgb = OFF; end
    endcase
  end

  assign state_o = state;

endmodule
